// File: rtl/lcd1602_pkg.sv
// Shared constants, state encoding and address helpers for the LCD1602 responder.
package lcd1602_pkg;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] ROW_LEN    = 7'd40;
    localparam logic [6:0] DDRAM_SIZE = 7'd80;
    localparam logic [7:0] BLANK      = 8'h20;

    typedef enum logic [1:0] {IDLE, EXEC, FILL, BUSY_WAIT} state_t;

    function automatic logic [6:0] ddram_idx(input logic [6:0] a, input logic n);
        return (n && a[6]) ? ROW_LEN + {1'b0, a[5:0]} : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                           input logic n, input logic cg);
        if (cg)
            return {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        if (n) begin
            if (up)
                return (a == LINE0_BASE + 7'd39) ? LINE1_BASE :
                       (a == LINE1_BASE + 7'd39) ? LINE0_BASE : a + 7'd1;
            return (a == LINE1_BASE) ? LINE0_BASE + 7'd39 :
                   (a == LINE0_BASE) ? LINE1_BASE + 7'd39 : a - 7'd1;
        end
        if (up)
            return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    function automatic logic [6:0] ddram_clamp(input logic [6:0] a, input logic n);
        if (n)
            return ((a <= 7'h27) || (a >= 7'h40 && a <= 7'h67)) ? a : 7'h00;
        return (a <= 7'h4F) ? a : 7'h00;
    endfunction

    function automatic logic [5:0] off_step(input logic [5:0] o, input logic up);
        if (up)
            return (o == 6'd39) ? 6'd0 : o + 6'd1;
        return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

endpackage

// File: rtl/lcd1602_strobe_sync.sv
// Brings the asynchronous host bus into clk, holds the last values seen while en was high
// and flags the synchronized falling edge of en.
module lcd1602_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic       en_s,
    output logic       en_fall,
    output logic       s_rs,
    output logic       s_rw,
    output logic       cap_rs,
    output logic       cap_rw,
    output logic [7:0] cap_data
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SS-1:0][10:0] sync_q;
    logic                en_d;

    assign en_s    = sync_q[SS-1][10];
    assign s_rs    = sync_q[SS-1][9];
    assign s_rw    = sync_q[SS-1][8];
    assign en_fall = en_d & ~en_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            en_d     <= 1'b0;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else begin
            sync_q <= {sync_q[SS-2:0], {lcd_en, lcd_rs, lcd_rw, lcd_data_in}};
            en_d   <= en_s;
            if (en_s)
                {cap_rs, cap_rw, cap_data} <= sync_q[SS-1][9:0];
        end
    end

endmodule

// File: rtl/lcd1602_responder.sv
// HD44780-compatible display-side responder: executes host commands into DDRAM/CGRAM
// and exposes a registered scan port for a downstream renderer.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int CMD_CYC     = 400,
    parameter int CLEAR_CYC   = 900,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic       scan_row,
    input  logic [3:0] scan_col,
    output logic [7:0] scan_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       cmd_dropped
);
    localparam int CLR = (CLEAR_CYC < 80) ? 80 : CLEAR_CYC;

    logic       en_s, en_fall, s_rs, s_rw, cap_rs, cap_rw;
    logic [7:0] cap_data;

    lcd1602_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in), .en_s(en_s), .en_fall(en_fall), .s_rs(s_rs),
        .s_rw(s_rw), .cap_rs(cap_rs), .cap_rw(cap_rw), .cap_data(cap_data)
    );

    logic [7:0] ddram [DDRAM_SIZE];
    logic [7:0] cgram [64];

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [6:0]  fill_idx, fill_d, ac_d;
    logic [5:0]  offset, off_d;
    logic        cg_sel, cg_d, inc_dir, id_d, disp_shift, sh_d;
    logic        disp_d, cur_d, blk_d, n_d, oe_d, drop_d;
    logic [7:0]  dout_d, scan_d, mem_rd, wdata;
    logic [6:0]  mem_idx, widx, scol, sidx;
    logic        we, cg_we;

    assign busy = (state != IDLE);

    always_comb begin
        state_d = state;   cnt_d  = cnt;     fill_d = fill_idx;  ac_d  = ac;
        cg_d    = cg_sel;  id_d   = inc_dir; sh_d   = disp_shift; off_d = offset;
        disp_d  = disp_on; cur_d  = cursor_on; blk_d = blink_on;  n_d   = two_line;
        dout_d  = lcd_data_out;
        we      = 1'b0;    cg_we  = 1'b0;    widx   = fill_idx;  wdata = BLANK;

        mem_idx = ddram_idx(ac, two_line);
        mem_rd  = cg_sel ? cgram[ac[5:0]] : (mem_idx < DDRAM_SIZE) ? ddram[mem_idx] : BLANK;

        // Reads are served regardless of busy; status shows the live busy flag.
        oe_d = en_s & s_rw;
        if (en_s && s_rw)
            dout_d = s_rs ? mem_rd : {busy, ac};
        if (en_fall && cap_rw && cap_rs)
            ac_d = ac_step(ac, inc_dir, two_line, cg_sel);
        drop_d = en_fall & ~cap_rw & busy;

        scol = {3'b000, scan_col} + {1'b0, offset};
        if (scol >= ROW_LEN)
            scol = scol - ROW_LEN;
        sidx   = scan_row ? scol + ROW_LEN : scol;
        scan_d = (state == FILL) ? BLANK : ddram[sidx];

        case (state)
            IDLE: if (en_fall && !cap_rw) state_d = EXEC;
            EXEC: begin
                state_d = BUSY_WAIT;
                cnt_d   = 16'(CMD_CYC - 1);
                if (cap_rs) begin
                    if (cg_sel)
                        cg_we = 1'b1;
                    else if (mem_idx < DDRAM_SIZE) begin
                        we = 1'b1; widx = mem_idx; wdata = cap_data;
                    end
                    ac_d = ac_step(ac, inc_dir, two_line, cg_sel);
                    if (disp_shift && !cg_sel)
                        off_d = off_step(offset, inc_dir);
                end else if (|(cap_data & OP_DDRAM)) begin
                    cg_d = 1'b0;
                    ac_d = ddram_clamp(cap_data[6:0], two_line);
                end else if (|(cap_data & OP_CGRAM)) begin
                    cg_d = 1'b1;
                    ac_d = {1'b0, cap_data[5:0]};
                end else if (|(cap_data & OP_FUNC)) begin
                    n_d = cap_data[3];
                end else if (|(cap_data & OP_SHIFT)) begin
                    // S/C selects display shift vs cursor move; R/L=0 means left.
                    if (cap_data[3])
                        off_d = off_step(offset, ~cap_data[2]);
                    else
                        ac_d = ac_step(ac, cap_data[2], two_line, cg_sel);
                end else if (|(cap_data & OP_DISP)) begin
                    {disp_d, cur_d, blk_d} = cap_data[2:0];
                end else if (|(cap_data & OP_ENTRY)) begin
                    id_d = cap_data[1];
                    sh_d = cap_data[0];
                end else if (|(cap_data & OP_HOME)) begin
                    ac_d = 7'h00; off_d = 6'd0; cnt_d = 16'(CLR - 1);
                end else if (|(cap_data & OP_CLEAR)) begin
                    state_d = FILL; fill_d = 7'd0; ac_d = 7'h00;
                    id_d    = 1'b1; off_d  = 6'd0; cnt_d = 16'(CLR - 1);
                end
            end
            FILL: begin
                we     = 1'b1;
                fill_d = fill_idx + 7'd1;
                cnt_d  = (cnt != 16'd0) ? cnt - 16'd1 : 16'd0;
                if (fill_idx == DDRAM_SIZE - 7'd1)
                    state_d = BUSY_WAIT;
            end
            BUSY_WAIT: begin
                if (cnt == 16'd0) state_d = IDLE;
                else              cnt_d   = cnt - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;    cnt <= 16'(CLR - 1); fill_idx <= 7'd0; ac <= 7'h00;
            cg_sel <= 1'b0;   inc_dir <= 1'b1;     disp_shift <= 1'b0; offset <= 6'd0;
            disp_on <= 1'b0;  cursor_on <= 1'b0;   blink_on <= 1'b0;  two_line <= 1'b1;
            lcd_data_out <= 8'h00; lcd_data_oe <= 1'b0; cmd_dropped <= 1'b0;
            scan_char <= BLANK;
        end else begin
            state <= state_d; cnt <= cnt_d;        fill_idx <= fill_d; ac <= ac_d;
            cg_sel <= cg_d;   inc_dir <= id_d;     disp_shift <= sh_d; offset <= off_d;
            disp_on <= disp_d; cursor_on <= cur_d; blink_on <= blk_d;  two_line <= n_d;
            lcd_data_out <= dout_d; lcd_data_oe <= oe_d; cmd_dropped <= drop_d;
            scan_char <= scan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            ddram[widx] <= wdata;
        if (cg_we)
            cgram[ac[5:0]] <= cap_data;
    end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed plus randomized bench for lcd1602_responder against an abstract display model.
module tb_lcd1602_responder;
    localparam int CMD_CYC   = 400;
    localparam int CLEAR_CYC = 900;
    localparam int SS        = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out, scan_char;
    logic       lcd_data_oe, busy, disp_on, cursor_on, blink_on, two_line, cmd_dropped;
    logic       scan_row = 1'b0;
    logic [3:0] scan_col = 4'd0;
    logic [6:0] ac;

    lcd1602_responder #(.CMD_CYC(CMD_CYC), .CLEAR_CYC(CLEAR_CYC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .scan_row(scan_row), .scan_col(scan_col), .scan_char(scan_char), .busy(busy),
        .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, drops = 0;
    always @(negedge clk) if (cmd_dropped === 1'b1) drops++;

    // Reference model: the display as 80 linear cells plus cursor/mode state.
    bit [7:0] dd_m [80];
    bit [7:0] cg_m [64];
    int ac_m, id_m, s_m, off_m, n_m, cgt_m, disp_m, cur_m, blk_m;

    function automatic int lin(int a);
        return (n_m != 0 && a >= 64) ? 40 + (a - 64) : a;
    endfunction
    function automatic int unlin(int p);
        return (n_m != 0 && p >= 40) ? 64 + (p - 40) : p;
    endfunction
    function automatic int step(int a, int dir);
        if (cgt_m != 0) return (a + 64 + dir) % 64;
        return unlin((lin(a) + 80 + dir) % 80);
    endfunction
    function automatic int mem_m();
        return (cgt_m != 0) ? int'(cg_m[ac_m]) : int'(dd_m[lin(ac_m)]);
    endfunction

    task automatic model_reset();
        foreach (dd_m[i]) dd_m[i] = 8'h20;
        ac_m = 0; id_m = 1; s_m = 0; off_m = 0; n_m = 1; cgt_m = 0;
        disp_m = 0; cur_m = 0; blk_m = 0;
    endtask

    task automatic model_write(input bit rs, input int d);
        int a;
        if (rs) begin
            if (cgt_m != 0) cg_m[ac_m] = 8'(d);
            else            dd_m[lin(ac_m)] = 8'(d);
            if (s_m != 0 && cgt_m == 0) off_m = (off_m + (id_m != 0 ? 1 : 39)) % 40;
            ac_m = step(ac_m, id_m != 0 ? 1 : -1);
        end else if (d >= 128) begin
            a = d - 128; cgt_m = 0;
            if (n_m != 0) ac_m = (a < 40 || (a >= 64 && a < 104)) ? a : 0;
            else          ac_m = (a < 80) ? a : 0;
        end else if (d >= 64) begin
            cgt_m = 1; ac_m = d - 64;
        end else if (d >= 32) begin
            n_m = (d >> 3) & 1;
        end else if (d >= 16) begin
            if ((d & 8) != 0) off_m = (off_m + ((d & 4) != 0 ? 39 : 1)) % 40;
            else              ac_m  = step(ac_m, (d & 4) != 0 ? 1 : -1);
        end else if (d >= 8) begin
            disp_m = (d >> 2) & 1; cur_m = (d >> 1) & 1; blk_m = d & 1;
        end else if (d >= 4) begin
            id_m = (d >> 1) & 1; s_m = d & 1;
        end else if (d >= 2) begin
            ac_m = 0; off_m = 0;
        end else if (d == 1) begin
            foreach (dd_m[i]) dd_m[i] = 8'h20;
            ac_m = 0; id_m = 1; off_m = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
        repeat (6) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (6) @(negedge clk);
        while (busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk({tag, "_timeout"}, busy, 0);
    endtask

    task automatic wr(input bit rs, input int d);
        strobe(rs, 1'b0, 8'(d));
        model_write(rs, d);
        wait_idle("wr");
    endtask

    task automatic rd(input bit rs, output logic [7:0] v, output logic o);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (6) @(negedge clk);
        v = lcd_data_out; o = lcd_data_oe;
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic scan_chk(input int row, input int col, input string tag);
        @(negedge clk);
        scan_row = row[0]; scan_col = col[3:0];
        @(negedge clk);
        chk(tag, scan_char, dd_m[row * 40 + (col + off_m) % 40]);
    endtask

    task automatic scan_all(input string tag);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) scan_chk(r, c, tag);
    endtask

    task automatic rand_ops(input int count);
        logic [7:0] v; logic o; int op, ch;
        for (int i = 0; i < count; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0:       wr(0, 128 + $urandom_range(0, 127));
                1, 2:    begin ch = $urandom_range(33, 126); wr(1, ch); end
                3:       wr(0, 4 + $urandom_range(0, 3));
                4:       wr(0, 16 + $urandom_range(0, 15));
                5: begin
                    rd(1, v, o);
                    chk("rnd_read", v, mem_m());
                    ac_m = step(ac_m, id_m != 0 ? 1 : -1);
                end
                default: begin
                    wr(0, 8 + $urandom_range(0, 7));
                    chk("rnd_dctl", {disp_on, cursor_on, blink_on}, {disp_m[0], cur_m[0], blk_m[0]});
                end
            endcase
            chk("rnd_ac", ac, ac_m);
            scan_chk($urandom_range(0, 1), $urandom_range(0, 15), "rnd_scan");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v; logic o; int n, pre;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_ac", ac, 0);
        chk("rst_dcb", {disp_on, cursor_on, blink_on}, 0);
        chk("rst_two_line", two_line, 1);
        chk("rst_oe", lcd_data_oe, 0);
        chk("rst_dout", lcd_data_out, 0);
        chk("rst_scan", scan_char, 8'h20);
        chk("rst_drop", cmd_dropped, 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("busy_min80", busy, 1);
        wait_idle("init");
        chk("init_busy_clear", busy, 0);
        chk("init_ac", ac, 0);
        scan_all("init_blank");

        // Typical init sequence and a short string
        wr(0, 8'h38); wr(0, 8'h08); wr(0, 8'h01); wr(0, 8'h06); wr(0, 8'h0C); wr(0, 8'h80);
        wr(1, "P"); wr(1, "a"); wr(1, "n");
        scan_chk(0, 0, "pan0"); scan_chk(0, 1, "pan1"); scan_chk(0, 2, "pan2");
        chk("pan_P", dd_m[0], "P");
        chk("pan_ac", ac, 3);
        chk("pan_disp", disp_on, 1);
        chk("pan_cursor", cursor_on, 0);
        chk("pan_drops", drops, 0);

        // End of line 0 wraps onto line 1
        wr(0, 8'hA7); wr(1, "X"); wr(1, "Y");
        chk("wrap_ac", ac, 7'h41);
        scan_chk(1, 0, "wrap_Y");
        wr(0, 8'hA7);
        rd(1, v, o);
        chk("wrap_read_X", v, "X");
        ac_m = step(ac_m, 1);
        chk("wrap_read_ac", ac, 7'h40);

        // Write while clearing is dropped
        strobe(0, 0, 8'h01); model_write(0, 1);
        repeat (20) @(negedge clk);
        strobe(1, 0, "Z");
        wait_idle("clr");
        chk("drop_count", drops, 1);
        chk("drop_ac", ac, 0);
        scan_all("drop_blank");

        // Status and data reads
        wr(0, 8'h85);
        strobe(1, 0, "Q"); model_write(1, "Q");
        repeat (20) @(negedge clk);
        rd(0, v, o);
        chk("status_busy", v, 8'h80 | 8'(ac_m));
        chk("status_oe", o, 1);
        chk("oe_release", lcd_data_oe, 0);
        wait_idle("q");
        rd(0, v, o);
        chk("status_idle", v, 8'(ac_m));
        rd(1, v, o);
        chk("data_read6", v, mem_m());
        ac_m = step(ac_m, 1);
        chk("data_read_ac", ac, 7);
        wr(0, 8'h85);
        rd(1, v, o);
        chk("data_read_Q", v, "Q");
        ac_m = step(ac_m, 1);

        // Display shift then return home
        wr(0, 8'h80); wr(1, "A"); wr(1, "B"); wr(1, "C"); wr(1, "D");
        wr(0, 8'h18); wr(0, 8'h18);
        scan_chk(0, 0, "shift2_c0");
        scan_chk(0, 1, "shift2_c1");
        chk("shift2_is_C", dd_m[off_m], "C");
        strobe(0, 0, 8'h02); model_write(0, 2);
        n = 0;
        while ((n < 6 || busy === 1'b1) && n < 3000) begin @(negedge clk); n++; end
        chk("home_busy_min", n >= CLEAR_CYC, 1);
        chk("home_busy_max", n <= CLEAR_CYC + 20, 1);
        chk("home_ac", ac, 0);
        scan_chk(0, 0, "home_scan");

        // CGRAM round trip
        pre = $urandom_range(0, 63);
        wr(0, 64 + pre); wr(1, 8'h15); wr(1, 8'h0A);
        chk("cg_ac", ac, (pre + 2) % 64);
        wr(0, 64 + pre);
        rd(1, v, o);
        chk("cg_read", v, 8'h15);
        ac_m = step(ac_m, 1);
        wr(0, 8'h80);

        rand_ops(20);
        wr(0, 8'h30); wr(0, 8'h80);
        chk("one_line", two_line, 0);
        rand_ops(15);
        drops = 0;

        // Reset in the middle of a command
        strobe(1, 0, "R");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_busy", busy, 1);
        wait_idle("midrst");
        chk("midrst_ac", ac, 0);
        chk("midrst_two_line", two_line, 1);
        scan_chk(0, 0, "midrst_scan0");
        scan_chk(1, 15, "midrst_scan1");
        chk("midrst_drops", drops, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- Synthesizable HD44780-compatible LCD1602 responder: the display-side end of the 8-bit parallel bus that our LCD writer drives.
- Decodes host strobes on lcd_rs/lcd_rw/lcd_en/lcd_data and executes the HD44780 command set.
- Holds DDRAM, CGRAM, the address counter, the busy flag and the display-shift state.
- Answers status and data reads, and exposes a scan port so a downstream renderer (VGA/OLED) or a testbench can read what is on screen.

Parameters:
- CMD_CYC, 400, busy duration in clk cycles for every command except clear/home, and for every data write.
- CLEAR_CYC, 900, busy duration in clk cycles for clear display and return home; values below 80 are treated as 80.
- SYNC_STAGES, 2, synchronizer depth on lcd_en, lcd_rs, lcd_rw and lcd_data (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_rs  in  1  register select: 0 = instruction/status, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_en  in  1  enable strobe, asynchronous to clk
- lcd_data_in  in  8  host-driven bus
- lcd_data_out  out  8  read-back data
- lcd_data_oe  out  1  high while the responder drives the bus
- scan_row  in  1  display line for the scan port
- scan_col  in  4  display column 0..15 for the scan port
- scan_char  out  8  character code at (scan_row, scan_col), shift applied
- busy  out  1  busy flag
- ac  out  7  address counter
- disp_on, cursor_on, blink_on  out  1 each  display control bits D, C, B
- two_line  out  1  function set N bit
- cmd_dropped  out  1  one-cycle pulse when a write strobe arrives while busy

Behaviour:
- Reset values:
  - ac=0, busy=1, disp_on=0, cursor_on=0, blink_on=0, two_line=1.
  - I/D=1, S=0, shift offset=0, DDRAM target selected.
  - lcd_data_out=0, lcd_data_oe=0, scan_char=0x20, cmd_dropped=0.
  - On reset release the block runs an internal clear (see FILL).
- Strobe handling:
  - lcd_en, lcd_rs, lcd_rw and lcd_data_in all pass through SYNC_STAGES flops.
  - While synchronized en is high, rs/rw/data are re-captured every cycle.
  - The synchronized falling edge of en executes the last captured values.
  - The host must hold en high for at least SYNC_STAGES+2 clk cycles; strobes shorter than that are undefined.
- Write, busy=0:
  - Instructions decode on the highest set bit:
    - 0x01 clear: enter FILL, ac=0, I/D=1, offset=0, busy for CLEAR_CYC.
    - 0x02/03 home: ac=0, offset=0, busy for CLEAR_CYC.
    - 0x04-07 entry mode: latch I/D (bit1) and S (bit0).
    - 0x08-0F display control: latch D, C, B.
    - 0x10-1F cursor/display shift:
      - S/C=1 shifts the display: offset +1 mod 40 when R/L=0 (left), -1 when R/L=1.
      - S/C=0 moves ac by ±1 using the wrap rules below.
    - 0x20-3F function set: latch N (bit3). DL and F are accepted and ignored; the block is 8-bit only.
    - 0x40-7F: CGRAM target, ac = data[5:0].
    - 0x80-FF: DDRAM target, ac = data[6:0].
  - Data write: store to DDRAM or CGRAM at ac, then step ac by I/D. If S=1 and the target is DDRAM, also shift the display in the same direction.
  - Every write sets busy for the listed duration; CMD_CYC unless stated otherwise.
- Write, busy=1: ignored entirely and cmd_dropped pulses; state is unchanged.
- Read (rw=1):
  - lcd_data_oe rises the cycle after synchronized en rises.
  - rs=0: lcd_data_out = {busy, ac}. Valid even while busy.
  - rs=1: lcd_data_out = memory[ac]. On en fall, ac steps by I/D; no busy is set.
  - lcd_data_oe falls on the synchronized en fall.
- DDRAM addressing:
  - Two-line mode: valid addresses are 0x00-0x27 and 0x40-0x67.
    - Physical index = addr[6] ? 40+addr[5:0] : addr.
    - Increment wraps 0x27->0x40 and 0x67->0x00. Decrement wraps the same boundaries in reverse.
    - Set-address writes to an invalid address clamp to 0x00.
  - One-line mode: addresses 0x00-0x4F, wrapping 0x4F<->0x00.
  - CGRAM addresses wrap mod 64.
- FILL state:
  - Writes 0x20 to one DDRAM location per cycle, indices 0..79. CGRAM is untouched.
  - busy stays high until both the FILL pass and the CLEAR_CYC counter have finished.
- Scan port:
  - scan_char = DDRAM[row*40 + (scan_col + offset) mod 40]; one-cycle registered latency.
  - While FILL is active it returns 0x20.
- Reset mid-operation aborts FILL, the busy count and any captured strobe, then restarts the internal clear.

Decomposition:
- Package lcd1602_pkg holds:
  - Instruction opcode masks and the line base addresses 0x00/0x40.
  - The row length constant (40).
  - The blank character 0x20.
  - The state enum IDLE / EXEC / FILL / BUSY_WAIT.
- One natural sub-module: lcd1602_strobe_sync (synchronizer, capture, en rise/fall pulses).

Test Plan:
- Reset release -> busy=1 for at least 80 cycles, then 0; scan (0,0) through (1,15) all read 0x20; ac=0.
- Host sequence 0x38, 0x08, 0x01, 0x06, 0x0C, 0x80, then data "Pan", strobes 1000 cycles apart -> scan(0,0..2)='P','a','n'; ac=3; disp_on=1; cursor_on=0; cmd_dropped never pulses.
- Instruction 0xA7, then data 'X','Y' -> 'X' at row0 col39 (index 39), 'Y' at index 40 (row1 col0); ac=0x41.
- Instruction 0x01, then a data write 20 cycles later -> cmd_dropped pulses once, DDRAM stays all 0x20, ac=0.
- Status read (rw=1, rs=0) inside the CMD_CYC window after a write at ac=5 -> lcd_data_out=0x86; after busy clears -> 0x06. Data read (rs=1) -> returns the stored char and ac increments to 7.
- Two 0x18 instructions -> offset=2 and scan(0,0)=DDRAM[2]; then 0x02 -> offset=0, ac=0, busy held for CLEAR_CYC cycles.
